// File: rtl/ram_arb_pkg.sv
// Shared definitions for the data-RAM arbiter: FSM state encoding and
// requester indices (port 0 = core load/store unit, port 1 = loader/debug).
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way request picker for the data-RAM arbiter.
// Default: round-robin, the port not granted last wins a tie.
// With RAM_ARB_FIXED_PRIO_EN defined: port 0 always wins a tie and the
// last-grant input is ignored.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  assign valid = |req;

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: core port wins whenever it requests.
  always_comb begin
    grant = PORT_LOAD;
    if (req[0]) grant = PORT_CORE;
  end
`else
  // Round-robin: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    grant = PORT_CORE;
    if (req == 2'b11)  grant = ~last;
    else if (req[1])   grant = PORT_LOAD;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing one single-port data RAM between the core (port 0) and the
// loader/debug master (port 1). One transaction every 3 cycles:
// IDLE (grant + capture) -> ACCESS (RAM strobe) -> RESP (ack pulse).
// Optional macro RAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  output logic                  o_ack0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_ack1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_write,
  output logic                  o_ram_read,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  output logic                  o_busy
);

  state_t                  state;
  logic                    cap_we;
  logic                    cap_port;
  logic                    last;
  logic                    ram_write_q;
  logic                    pick_port;
  logic                    pick_valid;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  rr_pick2 u_pick (
    .req   ({i_req1, i_req0}),
    .last  (last),
    .grant (pick_port),
    .valid (pick_valid)
  );

  assign sel_we    = (pick_port == PORT_LOAD) ? i_we1    : i_we0;
  assign sel_addr  = (pick_port == PORT_LOAD) ? i_addr1  : i_addr0;
  assign sel_wdata = (pick_port == PORT_LOAD) ? i_wdata1 : i_wdata0;

  // The write strobe is registered but gated by reset so a write whose
  // ACCESS cycle coincides with reset never reaches the RAM.
  assign o_ram_write = ram_write_q & ~i_rst;
  assign o_busy      = (state != ST_IDLE);

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign last = PORT_LOAD;
`else
  // Last-grant pointer; reset to port 1 so the core wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst)                                last <= PORT_LOAD;
    else if (state == ST_IDLE && pick_valid)  last <= pick_port;
  end
`endif

  // Transaction FSM with registered RAM strobes, acks and read data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      cap_we      <= 1'b0;
      cap_port    <= PORT_CORE;
      ram_write_q <= 1'b0;
      o_ram_read  <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_data  <= '0;
      o_ack0      <= 1'b0;
      o_ack1      <= 1'b0;
      o_rdata0    <= '0;
      o_rdata1    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            // The RAM address/data registers double as the capture registers.
            cap_port    <= pick_port;
            cap_we      <= sel_we;
            o_ram_addr  <= sel_addr;
            o_ram_data  <= sel_wdata;
            ram_write_q <= sel_we;
            o_ram_read  <= ~sel_we;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          ram_write_q <= 1'b0;
          o_ram_read  <= 1'b0;
          if (!cap_we) begin
            if (cap_port == PORT_LOAD) o_rdata1 <= i_ram_data;
            else                       o_rdata0 <= i_ram_data;
          end
          o_ack0 <= (cap_port == PORT_CORE);
          o_ack1 <= (cap_port == PORT_LOAD);
          state  <= ST_RESP;
        end
        ST_RESP: begin
          o_ack0 <= 1'b0;
          o_ack1 <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and a scoreboard
// of expected acks. Honours RAM_ARB_FIXED_PRIO_EN for the contention step.
module tb_ram_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req0, i_we0, i_req1, i_we1;
  logic [31:0] i_addr0, i_wdata0, i_addr1, i_wdata1;
  logic        o_ack0, o_ack1, o_ram_write, o_ram_read, o_busy;
  logic [31:0] o_rdata0, o_rdata1, o_ram_addr, o_ram_data, i_ram_data;

  typedef struct packed {
    logic        port;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem     [16];
  logic [31:0] exp_mem [16];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned wr_cycles = 0;
  logic        mon_en = 1'b0;

  ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0(i_req0), .i_we0(i_we0), .i_addr0(i_addr0), .i_wdata0(i_wdata0),
    .o_ack0(o_ack0), .o_rdata0(o_rdata0),
    .i_req1(i_req1), .i_we1(i_we1), .i_addr1(i_addr1), .i_wdata1(i_wdata1),
    .o_ack1(o_ack1), .o_rdata1(o_rdata1),
    .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
    .o_ram_write(o_ram_write), .o_ram_read(o_ram_read),
    .i_ram_data(i_ram_data), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural RAM: combinational read, write committed on the clock edge.
  assign i_ram_data = mem[o_ram_addr[3:0]];
  always @(posedge i_clk) if (o_ram_write) mem[o_ram_addr[3:0]] <= o_ram_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Per-cycle monitor: strobe/ack exclusivity and scoreboard pop on each ack.
  always @(negedge i_clk) begin
    if (mon_en) begin
      exp_t e;
      if (o_ram_write) wr_cycles++;
      check("strobe_excl", {31'b0, o_ram_write & o_ram_read}, 32'd0);
      if (o_ack0 | o_ack1) begin
        check("ack_excl", {31'b0, o_ack0 & o_ack1}, 32'd0);
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL sb_unexpected_ack: observed ack0=%0b ack1=%0b expected none", o_ack0, o_ack1);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_port", {31'b0, o_ack1}, {31'b0, e.port});
          if (e.rd) check("sb_rdata", e.port ? o_rdata1 : o_rdata0, e.data);
        end
      end
    end
  end

  // One transaction on `port`; optionally the other port contends with a read of addr 1.
  task automatic txn(input logic port, input logic we, input logic [3:0] addr,
                     input logic [31:0] wdata, input logic contend);
    int unsigned w0;
    if (port) begin i_req1 = 1; i_we1 = we; i_addr1 = {28'b0, addr}; i_wdata1 = wdata; end
    else      begin i_req0 = 1; i_we0 = we; i_addr0 = {28'b0, addr}; i_wdata0 = wdata; end
    if (contend) begin
      if (port) begin i_req0 = 1; i_we0 = 0; i_addr0 = 32'd1; end
      else      begin i_req1 = 1; i_we1 = 0; i_addr1 = 32'd1; end
    end
    sb.push_back('{port: port, rd: ~we, data: we ? 32'd0 : exp_mem[addr]});
    if (we) exp_mem[addr] = wdata;
    w0 = wr_cycles;
    @(negedge i_clk);
    check("idle_busy", {31'b0, o_busy}, 32'd0);
    @(negedge i_clk);
    check("acc_busy", {31'b0, o_busy}, 32'd1);
    check("acc_addr", o_ram_addr, {28'b0, addr});
    check("acc_write", {31'b0, o_ram_write}, {31'b0, we});
    check("acc_read", {31'b0, o_ram_read}, {31'b0, ~we});
    if (we) check("acc_wdata", o_ram_data, wdata);
    @(negedge i_clk);
    check("resp_ack_win", {31'b0, port ? o_ack1 : o_ack0}, 32'd1);
    check("resp_ack_lose", {31'b0, port ? o_ack0 : o_ack1}, 32'd0);
    if (!we) check("resp_rdata", port ? o_rdata1 : o_rdata0, exp_mem[addr]);
    @(posedge i_clk); #1;
    i_req0 = 0;
    i_req1 = 0;
    check("write_strobe_cycles", wr_cycles - w0, we ? 32'd1 : 32'd0);
  endtask

  initial begin
    int unsigned cnt0, cnt1, t0, t1;
    logic a0, a1;
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'hA500_0000 | i;
      exp_mem[i] = 32'hA500_0000 | i;
    end
    i_rst = 1; i_req0 = 1; i_we0 = 0; i_addr0 = 0; i_wdata0 = 0;
    i_req1 = 1; i_we1 = 0; i_addr1 = 32'd1; i_wdata1 = 0;

    // Reset held with both requests high: everything quiet.
    repeat (3) begin
      @(posedge i_clk); @(negedge i_clk);
      mon_en = 1;
      check("rst_quiet", {27'b0, o_ack0, o_ack1, o_ram_write, o_ram_read, o_busy}, 32'd0);
      check("rst_rdata", o_rdata0 | o_rdata1, 32'd0);
    end
    @(posedge i_clk); #1;
    i_rst = 0;
    // Port 0 wins the first tie after reset.
    txn(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);

    // Single write then read-back on port 0.
    txn(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0);
    txn(1'b0, 1'b0, 4'd5, 32'd0, 1'b0);

    // Isolation: port 1 write must not disturb o_rdata0.
    txn(1'b0, 1'b1, 4'd6, 32'd2, 1'b0);
    txn(1'b0, 1'b0, 4'd6, 32'd0, 1'b0);
    txn(1'b1, 1'b1, 4'd2, 32'd7, 1'b0);
    check("iso_rdata0_held", o_rdata0, 32'd2);
    txn(1'b0, 1'b0, 4'd2, 32'd0, 1'b0);

    // Reset during the ACCESS cycle of a port 1 write: write suppressed, no ack.
    i_req1 = 1; i_we1 = 1; i_addr1 = 32'd3; i_wdata1 = 32'd9;
    @(negedge i_clk);
    @(negedge i_clk);
    check("midrst_acc_busy", {31'b0, o_busy}, 32'd1);
    i_rst = 1;
    i_req1 = 0;
    #1;
    check("midrst_write_gated", {31'b0, o_ram_write}, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 0;
    repeat (3) begin
      @(negedge i_clk);
      check("midrst_quiet", {29'b0, o_ack1, o_ack0, o_busy}, 32'd0);
    end
    @(posedge i_clk); #1;

    // Contention: both ports read continuously for four transactions.
`ifdef RAM_ARB_FIXED_PRIO_EN
    t0 = 4; t1 = 0;
    repeat (4) sb.push_back('{port: 1'b0, rd: 1'b1, data: exp_mem[0]});
`else
    t0 = 2; t1 = 2;
    repeat (2) begin
      sb.push_back('{port: 1'b0, rd: 1'b1, data: exp_mem[0]});
      sb.push_back('{port: 1'b1, rd: 1'b1, data: exp_mem[1]});
    end
`endif
    cnt0 = 0; cnt1 = 0;
    i_req0 = 1; i_we0 = 0; i_addr0 = 32'd0;
    i_req1 = 1; i_we1 = 0; i_addr1 = 32'd1;
    for (int c = 0; c < 40 && (cnt0 + cnt1) < 4; c++) begin
      @(negedge i_clk);
      a0 = o_ack0; a1 = o_ack1;
      @(posedge i_clk); #1;
      if (a0) begin cnt0++; if (cnt0 == t0) i_req0 = 0; end
      if (a1) begin cnt1++; if (cnt1 == t1) i_req1 = 0; end
    end
    i_req0 = 0; i_req1 = 0;
    check("cont_total", cnt0 + cnt1, 32'd4);
    check("cont_port0", cnt0, t0);
    check("cont_port1", cnt1, t1);

    // The aborted write must have left RAM[3] at its original value.
    txn(1'b0, 1'b0, 4'd3, 32'd0, 1'b0);

    repeat (4) @(negedge i_clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 is the core load/store unit, port 1 is the loader/debug master.
- Each requester uses a req/ack handshake. The arbiter picks a winner, captures its request, and drives the RAM strobes for exactly one cycle. It then returns read data with a one-cycle ack pulse.
- Sits between the requesters and the RAM's i_addr/i_data/i_write/i_read/o_data pins.

Parameters:
- DATA_WIDTH, 32, width of RAM word and of read/write data.
- ADDR_WIDTH, 32, width of RAM address.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req0  in  1  port 0 request; held high until o_ack0 is seen.
- i_we0  in  1  port 0 direction: 1 = write, 0 = read.
- i_addr0  in  ADDR_WIDTH  port 0 address.
- i_wdata0  in  DATA_WIDTH  port 0 write data.
- o_ack0  out  1  port 0 completion pulse.
- o_rdata0  out  DATA_WIDTH  port 0 read data; valid while o_ack0 is high.
- i_req1, i_we1, i_addr1, i_wdata1, o_ack1, o_rdata1: same as port 0, for port 1.
- o_ram_addr  out  ADDR_WIDTH  to RAM i_addr.
- o_ram_data  out  DATA_WIDTH  to RAM i_data.
- o_ram_write  out  1  to RAM i_write.
- o_ram_read  out  1  to RAM i_read.
- i_ram_data  in  DATA_WIDTH  from RAM o_data (combinational read).
- o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clocking and reset: single clock i_clk. Reset is synchronous and active-high on i_rst.
- Reset values:
  - state = IDLE.
  - o_ack0 = o_ack1 = 0; o_rdata0 = o_rdata1 = 0.
  - o_ram_write = o_ram_read = 0; o_ram_addr = o_ram_data = 0.
  - o_busy = 0; last-grant pointer = 1, so port 0 wins first.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any i_reqN is high, pick a winner and capture its addr, wdata, we and index into registers; go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Round-robin. If both requests are high, the port that was not granted last wins.
  - A single requester always wins.
  - The pointer updates on every grant.
- ACCESS (exactly 1 cycle):
  - o_ram_addr and o_ram_data come from the captured registers.
  - o_ram_write = we & ~i_rst.
  - o_ram_read = ~we.
  - Read and write strobes are never high together.
  - On a read, i_ram_data is registered into o_rdataN of the winner. The RAM commits a write at the end of this cycle.
  - Next state is RESP.
- RESP (1 cycle):
  - o_ackN = 1 for the winner only; the other ack stays 0.
  - No arbitration in this cycle. Next state is IDLE.
- Requester rule: drop req on the edge that ends its ack cycle. A req still high in the following IDLE is treated as a new request.
- Latency: req sampled at edge E; RAM access in cycle E..E+1; ack high in cycle E+1..E+2. Throughput is one transaction per 3 cycles.
- o_rdataN:
  - Holds its last read value until that port's next read.
  - Is not modified by writes.
  - Is not modified by transactions on the other port.
- Outside ACCESS, RAM strobes are 0 and o_ram_addr/o_ram_data hold their last values.
- Changes to the loser's req/addr during a transaction are ignored. Changes to the winner's inputs after capture are ignored.
- Reset mid-operation:
  - Any state goes to IDLE; no ack is issued and no pending request is remembered.
  - A write whose ACCESS cycle coincides with i_rst high is suppressed (o_ram_write gated low).

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 always wins when both request. The last-grant pointer is not implemented. Port 1 may starve.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Package ram_arb_pkg holds:
  - state encoding constants ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2;
  - requester index constants PORT_CORE = 1'b0, PORT_LOAD = 1'b1.
- One sub-module: rr_pick2, a 2-way picker.
  - Inputs: req[1:0], last grant.
  - Outputs: grant index, valid.
  - The macro selects the fixed-priority variant inside rr_pick2.

Test Plan:
- Reset/idle: hold i_rst 3 cycles with both reqs high -> no ack, strobes 0, o_busy 0. After release, port 0 is granted first.
- Single write then read: port 0 writes addr 5 data 32'hDEADBEEF -> o_ram_write high exactly 1 cycle, o_ack0 two cycles after sampling. Port 0 reads addr 5 -> o_rdata0 = 32'hDEADBEEF with o_ack0, and o_ram_read is the only strobe.
- Contention round-robin: both reqs held high (port 0 reads addr 0, port 1 reads addr 1) -> grants alternate 0,1,0,1. o_ack1 never coincides with o_ack0. o_rdata0 = RAM[0], o_rdata1 = RAM[1].
- Isolation: port 1 writes addr 2 = 7 while o_rdata0 holds 2 -> o_rdata0 is unchanged. A later port 0 read of addr 2 returns 7.
- Reset mid-write: assert i_rst during the ACCESS cycle of a port 1 write of 9 to addr 3 -> no o_ack1, RAM[3] is unchanged (read back original), state returns to IDLE.
- With RAM_ARB_FIXED_PRIO_EN: both reqs continuously high for 4 transactions -> all 4 acks go to port 0 and o_ack1 stays 0.
